// File: rtl/ram_sp_ctrl_if.sv
// Request/response handshake bundle between a client and the single-port RAM controller.
// The controller sits on the slave side; the request issuer sits on the master side.
interface ram_sp_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_sp_ctrl.sv
// Converts a valid/ready request stream into cs/we/oe/address strobes for a single-port
// synchronous RAM, owns the write side of the shared data bus, returns reads on a response channel.
module ram_sp_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_sp_ctrl_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] ram_address,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);
    typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, TURN} state_t;

    state_t                state_q, state_d;
    logic                  cs_d, we_d, oe_d, drv_d;
    logic                  drv_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  accept;
    logic                  capture;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    assign accept  = bus.req_valid && (state_q == IDLE);
    assign capture = (state_q == RD_D) && (!rsp_valid_q || bus.rsp_ready);

    // The drive enable is a register tied to WR, so the bus is never driven while oe is high.
    assign ram_data = drv_q ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        oe_d    = 1'b0;
        drv_d   = 1'b0;
        case (state_q)
            IDLE:    if (accept) state_d = bus.req_we ? WR : RD_A;
            WR:      state_d = IDLE;
            RD_A:    state_d = RD_D;
            RD_D:    if (capture) state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Strobes are decoded from the next state and registered, keeping RAM pins glitch-free.
        case (state_d)
            WR: begin
                cs_d  = 1'b1;
                we_d  = 1'b1;
                drv_d = 1'b1;
            end
            RD_A, RD_D: begin
                cs_d = 1'b1;
                oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_oe      <= 1'b0;
            drv_q       <= 1'b0;
            ram_address <= '0;
            wdata_q     <= '0;
        end else begin
            ram_cs <= cs_d;
            ram_we <= we_d;
            ram_oe <= oe_d;
            drv_q  <= drv_d;
            if (accept) begin
                ram_address <= bus.req_addr;
                wdata_q     <= bus.req_wdata;
            end
        end
    end

    // Capture and consume on the same edge keep valid high with the new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (capture) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ram_data;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Bench for ram_sp_ctrl: behavioral single-port synchronous RAM, directed traffic,
// a queue scoreboard drained by a response monitor, and bus-ownership watchers.
module tb_ram_sp_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_sp_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();
    logic [7:0] ram_address;
    wire  [7:0] ram_data;
    logic       ram_cs, ram_we, ram_oe;

    ram_sp_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ram_address(ram_address), .ram_data(ram_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
    );

    // RAM model: synchronous write, registered read, drives the bus while selected for read
    logic [7:0] mem [256];
    logic [7:0] rd_q;
    always @(posedge clk) begin
        if (ram_cs && ram_we)  mem[ram_address] <= ram_data;
        if (ram_cs && !ram_we) rd_q <= mem[ram_address];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? rd_q : 8'hzz;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int we_cnt   = 0;
    int viol     = 0;
    logic prev_oe = 1'b0;
    logic rnd_en  = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;
    logic [7:0] shadow [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: every consumed response must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else begin
                exp_v = exp_q.pop_front();
                chk("rsp_data", {24'd0, bus.rsp_rdata}, {24'd0, exp_v});
            end
        end
    end

    // Bus ownership: writes never overlap output enable; reads always end with an all-off cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we) we_cnt++;
            if (ram_we && (ram_oe || !ram_cs)) viol++;
            if (prev_oe && !ram_oe && (ram_cs || ram_we)) viol++;
        end
        prev_oe = ram_oe;
    end

    always @(posedge clk) begin
        if (rnd_en) begin
            #1;
            bus.rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d, output int t);
        int   n   = 0;
        logic acc = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        t = cyc;
        bus.req_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, output int t);
        send(1'b1, a, d, t);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e, output int t);
        exp_q.push_back(e);
        send(1'b0, a, 8'h00, t);
    endtask

    initial begin
        int t0, t1, snap, n;
        int ts [4];
        logic [7:0] a, d;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
        chk("rst_addr", {24'd0, ram_address}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // write then read with latency checks
        snap = we_cnt;
        wr(8'h10, 8'hA5, t0);
        repeat (2) @(posedge clk);
        #1;
        chk("we_one_cycle", we_cnt, snap + 1);
        wr(8'h20, 8'h5A, t0);
        rd(8'h10, 8'hA5, t0);
        @(posedge clk); #1;
        chk("rd_valid_E1", {31'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("rd_valid_E2", {31'd0, bus.rsp_valid}, 32'd1);
        chk("rd_data_E2", {24'd0, bus.rsp_rdata}, 32'hA5);
        repeat (3) @(posedge clk);

        // back-to-back writes then reads
        for (int i = 0; i < 4; i++) begin
            a = 8'(i);
            d = 8'(8'h11 * (i + 1));
            wr(a, d, ts[i]);
        end
        for (int i = 1; i < 4; i++) chk("wr_spacing", ts[i] - ts[i-1], 32'd2);
        for (int i = 0; i < 4; i++) begin
            a = 8'(i);
            d = 8'(8'h11 * (i + 1));
            rd(a, d, ts[i]);
        end
        for (int i = 1; i < 4; i++) chk("rd_spacing", ts[i] - ts[i-1], 32'd4);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_drained", exp_q.size(), 32'd0);

        // response backpressure
        bus.rsp_ready = 1'b0;
        rd(8'h10, 8'hA5, t0);
        rd(8'h20, 8'h5A, t1);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("bp_hold_data", {24'd0, bus.rsp_rdata}, 32'hA5);
        chk("bp_in_rd_d", {29'd0, ram_cs, ram_we, ram_oe}, 32'b101);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_new_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("bp_new_data", {24'd0, bus.rsp_rdata}, 32'h5A);
        repeat (4) @(posedge clk);

        // reset in the middle of a read, while in RD_D
        bus.rsp_ready = 1'b0;
        send(1'b0, 8'h20, 8'h00, t0);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("midrst_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
        chk("midrst_addr", {24'd0, ram_address}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // random traffic with random consumer backpressure
        for (int i = 0; i < 4; i++) begin
            a = 8'(8'h30 + i);
            d = 8'($urandom_range(0, 255));
            shadow[i] = d;
            wr(a, d, t0);
        end
        rnd_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int idx;
            idx = $urandom_range(0, 3);
            a = 8'(8'h30 + idx);
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom_range(0, 255));
                shadow[idx] = d;
                wr(a, d, t0);
            end else begin
                rd(a, shadow[idx], t0);
            end
        end
        rnd_en = 1'b0;
        @(posedge clk); #2;
        bus.rsp_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("final_drained", exp_q.size(), 32'd0);
        chk("bus_ownership_viol", viol, 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/ram_sp_ctrl.md
# ram_sp_ctrl

Request-driven access controller that sits directly upstream of the single-port synchronous RAM (`ram_sp_sr_sw`). It converts a valid/ready read/write request stream into that RAM's `cs`/`we`/`oe`/`address` strobes. It owns the write side of the shared bidirectional data bus and returns read data on a valid/ready response channel. Only one access is outstanding at a time, and the bus turnaround after every read is explicit.

## Interface
- `DATA_WIDTH`, 8, width of the request, response and RAM data bus.
- `ADDR_WIDTH`, 8, width of the request address and RAM address.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller accepts a request this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  request address.
- `req_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  DATA_WIDTH  read data.
- `ram_address`  out  ADDR_WIDTH  to RAM `address`.
- `ram_data`  inout  DATA_WIDTH  to RAM `data`; driven only during a write, high-Z otherwise.
- `ram_cs`, `ram_we`, `ram_oe`  out  1 each  RAM chip select, write enable and output enable.

## Operation
- The FSM has 5 states: IDLE, WR, RD_A, RD_D, TURN.
- **Request acceptance**
  - `req_ready` = (state == IDLE).
  - A request is accepted on an edge where `req_valid && req_ready`.
  - On acceptance, `req_addr`, `req_we` and `req_wdata` are latched into internal registers.
  - The request inputs are not used after acceptance.
- **IDLE**
  - Outputs: `ram_cs` = `ram_we` = `ram_oe` = 0; bus released.
  - Transitions: accepted write -> WR; accepted read -> RD_A.
- **WR**
  - Outputs: `ram_cs` = 1, `ram_we` = 1, `ram_oe` = 0; latched address on `ram_address`; latched data driven on `ram_data`.
  - Transition: -> IDLE unconditionally. The RAM writes on the edge that leaves WR.
- **RD_A**
  - Outputs: `ram_cs` = 1, `ram_we` = 0, `ram_oe` = 1; bus released.
  - Transition: -> RD_D. The RAM loads its read register on this edge.
- **RD_D**
  - Outputs: same as RD_A. The RAM drives `ram_data`.
  - If (`!rsp_valid || rsp_ready`): capture `ram_data` into `rsp_rdata`, set `rsp_valid` = 1, go to TURN.
  - Otherwise stay in RD_D. The RAM re-reads the same address each cycle, so the data stays stable.
- **TURN**
  - All strobes 0, bus released; one dead cycle for bus turnaround.
  - Transition: -> IDLE.
- **Response channel**
  - `rsp_valid` stays high, with `rsp_rdata` stable, until an edge with `rsp_ready` = 1.
  - A capture and a consume on the same edge leave `rsp_valid` = 1 with the new data.
- `ram_cs`, `ram_we`, `ram_oe` and `ram_address` are registered; no combinational path from request inputs to RAM pins.
- The controller never drives `ram_data` while `ram_oe` = 1, so no contention.
- Writes are accepted even while a response is pending; only read capture stalls.

## Timing
- **Reset**
  - Takes effect immediately, at any point including mid-access.
  - Forces state IDLE; `ram_cs` = `ram_we` = `ram_oe` = 0; `ram_address` = 0; `ram_data` high-Z.
  - Clears `rsp_valid` to 0 and `rsp_rdata` to 0. A pending response is discarded.
  - `req_ready` = 1 once `rst_n` is high.
- **Write**
  - Acceptance at edge E0; WR during E0–E1; memory updated at E1.
  - Next acceptance possible at E2, so write throughput is 1 per 2 cycles.
- **Read**
  - Acceptance at edge E0; RD_A during E0–E1; RD_D during E1–E2.
  - `rsp_valid` rises at E2 when the response slot is free.
  - TURN during E2–E3; next acceptance at E4, so read throughput is 1 per 4 cycles.
- **Backpressure**
  - Each cycle `rsp_valid && !rsp_ready` holds in RD_D adds one cycle to the read latency.
- **Ordering**
  - Accesses complete in acceptance order.
  - A read that follows a write to the same address returns the new data.

## Test plan
- **Reset values:** assert `rst_n` = 0 mid-read, in RD_D -> all strobes 0 immediately, bus Z, `rsp_valid` = 0; after release, `req_ready` = 1.
- **Write then read:** write 0xA5 to address 0x10, then read 0x10 -> `ram_we` high for exactly 1 cycle; `rsp_rdata` = 0xA5 with `rsp_valid` at E2 of the read.
- **Back-to-back writes:** write addresses 0x00–0x03 with data 0x11, 0x22, 0x33, 0x44, `req_valid` held high -> one acceptance every 2 cycles; reading them back returns the same values in order.
- **Response backpressure:** read 0x10 with `rsp_ready` = 0 for 5 cycles, then a second read of 0x20 (holding 0x5A) -> controller holds in RD_D; `rsp_rdata` stays 0xA5 until consumed, then becomes 0x5A on the following edge.
- **Same-edge capture and consume:** `rsp_ready` tied to 1 during consecutive reads -> `rsp_valid` pulses 1 cycle per read; no data lost or duplicated.
- **Bus ownership check:** across random traffic, the assertion "`ram_data` driven by controller ⇒ `ram_we` = 1 and `ram_oe` = 0" holds, and a TURN cycle always follows RD_D.
